// File: rtl/noc3_msg_injector_pkg.sv
// Shared types and field layout for the noc3 message injector.
// Flit field positions, message-type codes and length encodings live here.
package noc3_msg_injector_pkg;

  typedef enum logic [1:0] {IDLE, HDR, ADDR, DATA} state_t;

  localparam int HDR_CHIPID_LSB = 50;
  localparam int HDR_X_LSB      = 42;
  localparam int HDR_Y_LSB      = 34;
  localparam int HDR_LEN_LSB    = 22;
  localparam int HDR_TYPE_LSB   = 14;
  localparam int HDR_SRC_LSB    = 0;
  localparam int ADDR_TAG_LSB   = 14;

  localparam logic [7:0] MSG_TYPE_INV_FWDACK   = 8'd16;
  localparam logic [7:0] MSG_TYPE_FWDACK       = 8'd17;
  localparam logic [7:0] MSG_TYPE_DATA_ACK     = 8'd24;
  localparam logic [7:0] MSG_TYPE_NODATA_ACK   = 8'd25;

  localparam logic [7:0] LEN_NODATA = 8'd1;
  localparam logic [7:0] LEN_DATA   = 8'd2;

  typedef struct packed {
    logic [7:0]  mtype;
    logic [25:0] tag;
    logic [5:0]  source;
    logic [63:0] data;
    logic        has_data;
  } msg_t;

endpackage

// File: rtl/noc3_msg_injector_flit.sv
// Combinational header/address flit formatter.
module noc_flit_builder
  import noc3_msg_injector_pkg::*;
(
  input  logic [7:0]  mtype,
  input  logic [25:0] tag,
  input  logic [5:0]  source,
  input  logic        has_data,
  input  logic [13:0] chipid,
  input  logic [7:0]  coreid_x,
  input  logic [7:0]  coreid_y,
  output logic [63:0] hdr_flit,
  output logic [63:0] addr_flit
);

  always_comb begin
    hdr_flit = '0;
    hdr_flit[HDR_CHIPID_LSB +: 14] = chipid;
    hdr_flit[HDR_X_LSB +: 8]       = coreid_x;
    hdr_flit[HDR_Y_LSB +: 8]       = coreid_y;
    hdr_flit[HDR_LEN_LSB +: 8]     = has_data ? LEN_DATA : LEN_NODATA;
    hdr_flit[HDR_TYPE_LSB +: 8]    = mtype;
    hdr_flit[HDR_SRC_LSB +: 6]     = source;
    addr_flit = '0;
    addr_flit[ADDR_TAG_LSB +: 26]  = tag;
  end

endmodule

// File: rtl/noc3_msg_injector.sv
// Serialises one accepted request into 2 or 3 noc3 flits toward an L2 tile,
// with a message counter and a sticky stall-timeout flag.
module noc3_msg_injector
  import noc3_msg_injector_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_type,
  input  logic [25:0] req_tag,
  input  logic [5:0]  req_source,
  input  logic [63:0] req_data,
  input  logic        req_has_data,
  input  logic [13:0] chipid,
  input  logic [7:0]  coreid_x,
  input  logic [7:0]  coreid_y,
  output logic        noc_valid_out,
  output logic [63:0] noc_data_out,
  input  logic        noc_ready_in,
  output logic        busy,
  output logic [7:0]  msg_cnt,
  output logic        err_timeout
);

  localparam logic [7:0] TO = TIMEOUT_CYCLES[7:0];

  state_t      state;
  msg_t        msg_q, msg_in, fld;
  logic [63:0] hdr_flit, addr_flit;
  logic [7:0]  stall_cnt, stall_nxt;
  logic        xfer;

  assign msg_in = '{mtype: req_type, tag: req_tag, source: req_source,
                    data: req_data, has_data: req_has_data};
  // Header is registered at acceptance, so format from the live request then.
  assign fld       = (state == IDLE) ? msg_in : msg_q;
  assign xfer      = noc_valid_out && noc_ready_in;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign stall_nxt = stall_cnt + 8'd1;

  noc_flit_builder u_build (
    .mtype    (fld.mtype),
    .tag      (fld.tag),
    .source   (fld.source),
    .has_data (fld.has_data),
    .chipid   (chipid),
    .coreid_x (coreid_x),
    .coreid_y (coreid_y),
    .hdr_flit (hdr_flit),
    .addr_flit(addr_flit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      msg_q         <= '0;
      noc_valid_out <= 1'b0;
      noc_data_out  <= '0;
      msg_cnt       <= '0;
      stall_cnt     <= '0;
      err_timeout   <= 1'b0;
    end else begin
      if (xfer) begin
        stall_cnt <= '0;
      end else if (noc_valid_out && stall_cnt != TO) begin
        stall_cnt <= stall_nxt;
        if (stall_nxt == TO) err_timeout <= 1'b1;
      end

      case (state)
        IDLE: if (req_valid) begin
          msg_q         <= msg_in;
          state         <= HDR;
          noc_valid_out <= 1'b1;
          noc_data_out  <= hdr_flit;
        end
        HDR: if (xfer) begin
          state        <= ADDR;
          noc_data_out <= addr_flit;
        end
        ADDR: if (xfer) begin
          if (msg_q.has_data) begin
            state        <= DATA;
            noc_data_out <= msg_q.data;
          end else begin
            state         <= IDLE;
            noc_valid_out <= 1'b0;
            noc_data_out  <= '0;
            msg_cnt       <= msg_cnt + 8'd1;
          end
        end
        DATA: if (xfer) begin
          state         <= IDLE;
          noc_valid_out <= 1'b0;
          noc_data_out  <= '0;
          msg_cnt       <= msg_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/noc3_msg_injector.md
NOC3_MSG_INJECTOR -- requirements
Module: noc3_msg_injector

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: stall cycles before err_timeout sets.
REQ-002 SHALL have clk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have req_valid  input  1  message offered.
REQ-005 SHALL have req_ready  output  1  message accepted this cycle when high with req_valid.
REQ-006 SHALL have req_type  input  8  NoC message type, for example FWDACK.
REQ-007 SHALL have req_tag  input  26  line tag.
REQ-008 SHALL have req_source  input  6  sender core id.
REQ-009 SHALL have req_data  input  64  payload word.
REQ-010 SHALL have req_has_data  input  1  payload flit present.
REQ-011 SHALL have chipid  input  14 and coreid_x, coreid_y  input  8 each: destination L2 tile.
REQ-012 SHALL have noc_valid_out  output  1, noc_data_out  output  64 and noc_ready_in  input  1: the flit channel to the L2 noc3 port.
REQ-013 SHALL have busy  output  1, msg_cnt  output  8 and err_timeout  output  1.

Function
REQ-014 SHALL implement the FSM states IDLE, HDR, ADDR and DATA.
REQ-015 SHALL drive req_ready = 1 only in IDLE; on req_valid&&req_ready it SHALL latch all req_* fields and move to HDR next cycle.
REQ-016 SHALL drive noc_valid_out = 1 in HDR, ADDR and DATA, and 0 in IDLE.
REQ-017 SHALL build the header flit as: [63:50] chipid, [49:42] coreid_x, [41:34] coreid_y, [33:30] 0, [29:22] length (1 without data, 2 with data), [21:14] type, [13:6] 0, [5:0] source.
REQ-018 SHALL build the address flit as: [63:40] 0, [39:14] tag, [13:0] 0.
REQ-019 SHALL send the data flit as the latched req_data.
REQ-020 SHALL transfer a flit only when noc_valid_out&&noc_ready_in; otherwise the flit and state SHALL hold unchanged.
REQ-021 SHALL follow the transitions HDR->ADDR; ADDR->DATA if has_data, else ADDR->IDLE; DATA->IDLE, each on transfer only.
REQ-022 SHALL take 2 cycles from acceptance to the first flit transfer with no backpressure, one flit per cycle after that, and re-accept in the cycle after the last transfer.
REQ-023 SHALL drive busy = (state != IDLE).
REQ-024 SHALL increment msg_cnt by 1 on each final-flit transfer, wrapping 255->0.
REQ-025 SHALL use an 8-bit stall counter: +1 each cycle with valid&&!ready, saturating at TIMEOUT_CYCLES, cleared on any transfer.
REQ-026 SHALL set err_timeout (sticky until rst) when the stall counter reaches TIMEOUT_CYCLES; transmission SHALL continue.
REQ-027 SHALL not sample req_* while busy; changes to req_* during a message SHALL not affect the flits in flight.

Reset
REQ-028 SHALL, on rst, set state to IDLE, req_ready to 1 on the next cycle, noc_valid_out 0, noc_data_out 0, busy 0, msg_cnt 0, err_timeout 0 and the stall counter 0.
REQ-029 SHALL, on rst asserted mid-message, abandon the message with no further flits and deassert noc_valid_out in the next cycle.

Structure
REQ-030 SHALL take from the shared package: FSM state enum, header field bit positions, message-type constants (incl. FWDACK), length encodings.
REQ-031 SHALL use one sub-module, noc_flit_builder: combinational header/address formatter from latched fields.

Verification
REQ-032 SHALL be verified with: type=FWDACK, tag=0x1234567, source=5, has_data=0, ready=1 -> header length=1, address flit [39:14]=0x1234567, msg_cnt=1, idle 2 cycles after the header transfer.
REQ-033 SHALL be verified with: has_data=1, data=0xDEADBEEF_CAFEF00D -> 3 flits, header length=2, third flit equals the data.
REQ-034 SHALL be verified with: noc_ready_in low for 10 cycles during ADDR -> address flit held stable for all 10 cycles, err_timeout stays 0.
REQ-035 SHALL be verified with: TIMEOUT_CYCLES=4, ready low for 6 cycles -> err_timeout rises after the 4th stall cycle, the message still completes when ready returns.
REQ-036 SHALL be verified with: rst in DATA -> noc_valid_out=0 next cycle, msg_cnt=0, req_ready=1.
REQ-037 SHALL be verified with: 256 messages back-to-back -> msg_cnt wraps to 0.
